// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request outstanding at a time; responses return in order.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// buffers returned words in a small FIFO whose head feeds decode.
//
//  state  | meaning
//  S_IDLE | nothing in flight; request when the FIFO has room
//  S_REQ  | request presented, waiting for grant (address held)
//  S_WAIT | one request granted, waiting for its read data
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        incr_pc_i,
  input  logic        pc_load_i,
  input  logic [31:0] pc_load_addr_i,
  fetch_unit_if.master imem,
  output logic [31:0] d_inst_o,
  output logic [31:0] d_pc_o,
  output logic        d_valid_o
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic          drop_q, drop_d;
  logic [31:0]   pc_q, req_pc_q;
  logic [31:0]   mem_inst [IBUF_DEPTH];
  logic [31:0]   mem_pc   [IBUF_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic          req, hs, push, pop, space, space_after_rsp;
  logic [CW-1:0] occ, occ_rsp;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^pc_load_addr_i[1:0];

  // Room is judged on registered occupancy only; a same-cycle pop earns no credit.
  always_comb begin
    occ             = count_q + CW'(state_q == S_WAIT);
    space           = occ < DEPTH_C;
    push            = (state_q == S_WAIT) && imem.imem_rvalid_i && !drop_q && !pc_load_i;
    occ_rsp         = count_q + CW'(push);
    space_after_rsp = occ_rsp < DEPTH_C;
    pop             = incr_pc_i && (count_q != '0);
  end

  always_comb begin
    req     = 1'b0;
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        req = space && !pc_load_i;
        if (req) state_d = imem.imem_gnt_i ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        req = !pc_load_i;
        if (pc_load_i)             state_d = S_IDLE;
        else if (imem.imem_gnt_i)  state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid_i) begin
          drop_d = 1'b0;
          req    = space_after_rsp && !pc_load_i;
          if (req) state_d = imem.imem_gnt_i ? S_WAIT : S_REQ;
          else     state_d = S_IDLE;
        end else if (pc_load_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hs               = req && imem.imem_gnt_i;
  assign imem.imem_req_o  = req && !rst_i;
  assign imem.imem_addr_o = pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      drop_q   <= 1'b0;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      assert (!(push && count_q == DEPTH_C));
      state_q <= state_d;
      drop_q  <= drop_d;
      if (pc_load_i)  pc_q <= {pc_load_addr_i[31:2], 2'b00};
      else if (hs)    pc_q <= pc_q + 32'd4;
      if (hs) req_pc_q <= pc_q;
      // A redirect flushes the buffer and wins over any push or pop.
      if (pc_load_i) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_inst[wr_ptr_q] <= imem.imem_rdata_i;
      mem_pc[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign d_valid_o = (count_q != '0);
  assign d_inst_o  = d_valid_o ? mem_inst[rd_ptr_q] : NOP_INST;
  assign d_pc_o    = d_valid_o ? mem_pc[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, grant stall,
// async reset and PC wrap, with hand-computed expectations.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        incr_pc_i;
  logic        pc_load_i;
  logic [31:0] pc_load_addr_i;
  logic [31:0] d_inst_o;
  logic [31:0] d_pc_o;
  logic        d_valid_o;
  logic        auto_rsp;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .incr_pc_i      (incr_pc_i),
    .pc_load_i      (pc_load_i),
    .pc_load_addr_i (pc_load_addr_i),
    .imem           (bus.master),
    .d_inst_o       (d_inst_o),
    .d_pc_o         (d_pc_o),
    .d_valid_o      (d_valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; in auto mode memory answers one cycle after a grant.
  task automatic step();
    logic        hs;
    logic [31:0] a;
    hs = bus.imem_req_o & bus.imem_gnt_i;
    a  = bus.imem_addr_o;
    @(posedge clk_i);
    #1;
    if (auto_rsp) begin
      bus.imem_rvalid_i = hs;
      bus.imem_rdata_i  = hs ? word(a) : 32'h0;
    end
  endtask

  initial begin
    rst_i = 1'b1; incr_pc_i = 1'b0; pc_load_i = 1'b0; pc_load_addr_i = 32'h0;
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;
    auto_rsp = 1'b1;
    #1;
    chk("rst_req",    {31'b0, bus.imem_req_o}, 32'd0);
    chk("rst_addr",   bus.imem_addr_o, 32'h0);
    chk("rst_valid",  {31'b0, d_valid_o}, 32'd0);
    chk("rst_inst",   d_inst_o, NOP);
    chk("rst_pc",     d_pc_o, 32'h0);

    // streaming with immediate grant and next-cycle data
    step(); rst_i = 1'b0; bus.imem_gnt_i = 1'b1; incr_pc_i = 1'b1; #1;
    chk("t1_req_c0",  {31'b0, bus.imem_req_o}, 32'd1);
    chk("t1_addr_c0", bus.imem_addr_o, 32'h0);
    step(); #1;
    chk("t1_addr_c1", bus.imem_addr_o, 32'h4);
    chk("t1_req_c1",  {31'b0, bus.imem_req_o}, 32'd1);
    step(); #1;
    chk("t1_valid_c2", {31'b0, d_valid_o}, 32'd1);
    chk("t1_pc_c2",    d_pc_o, 32'h0);
    chk("t1_inst_c2",  d_inst_o, word(32'h0));
    chk("t1_req_full", {31'b0, bus.imem_req_o}, 32'd0);
    step(); #1;
    chk("t1_pc_c3",   d_pc_o, 32'h4);
    chk("t1_addr_c3", bus.imem_addr_o, 32'h8);
    step(); #1;
    chk("t1_valid_c4", {31'b0, d_valid_o}, 32'd0);
    chk("t1_addr_c4",  bus.imem_addr_o, 32'hC);
    step();
    chk("t1_pc_c5",   d_pc_o, 32'h8);

    // decode stall: FIFO fills to two entries and requests stop
    incr_pc_i = 1'b0; #1;
    chk("t2_req_c5",  {31'b0, bus.imem_req_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_hold_pc",   d_pc_o, 32'h8);
      chk("t2_hold_inst", d_inst_o, word(32'h8));
      chk("t2_hold_req",  {31'b0, bus.imem_req_o}, 32'd0);
    end
    incr_pc_i = 1'b1; #1;
    chk("t2_rel_req", {31'b0, bus.imem_req_o}, 32'd0);
    step(); #1;
    chk("t2_rel_pc",   d_pc_o, 32'hC);
    chk("t2_rel_inst", d_inst_o, word(32'hC));
    chk("t2_rel_addr", bus.imem_addr_o, 32'h10);
    auto_rsp = 1'b0;

    // redirect while a request is outstanding
    step();
    chk("t3_empty", {31'b0, d_valid_o}, 32'd0);
    pc_load_i = 1'b1; pc_load_addr_i = 32'h0000_0103; #1;
    chk("t3_req_redir", {31'b0, bus.imem_req_o}, 32'd0);
    step();
    pc_load_i = 1'b0; incr_pc_i = 1'b0; #1;
    chk("t3_addr_tgt", bus.imem_addr_o, 32'h100);
    chk("t3_req_wait", {31'b0, bus.imem_req_o}, 32'd0);
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h10); #1;
    chk("t3_req_after_stale", {31'b0, bus.imem_req_o}, 32'd1);
    chk("t3_addr_after_stale", bus.imem_addr_o, 32'h100);
    step();
    chk("t3_stale_dropped", {31'b0, d_valid_o}, 32'd0);
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h100); bus.imem_gnt_i = 1'b0; #1;
    step();
    bus.imem_rvalid_i = 1'b0; #1;
    chk("t3_valid", {31'b0, d_valid_o}, 32'd1);
    chk("t3_pc",    d_pc_o, 32'h100);
    chk("t3_inst",  d_inst_o, word(32'h100));

    // redirect coinciding with rvalid and a pop
    bus.imem_gnt_i = 1'b1; #1;
    chk("t4_req",  {31'b0, bus.imem_req_o}, 32'd1);
    chk("t4_addr", bus.imem_addr_o, 32'h104);
    step();
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h104);
    pc_load_i = 1'b1; pc_load_addr_i = 32'h0000_0200; incr_pc_i = 1'b1; bus.imem_gnt_i = 1'b0; #1;
    chk("t4_req_redir", {31'b0, bus.imem_req_o}, 32'd0);
    step();
    bus.imem_rvalid_i = 1'b0; pc_load_i = 1'b0; incr_pc_i = 1'b0; #1;
    chk("t4_flushed", {31'b0, d_valid_o}, 32'd0);
    chk("t4_inst",    d_inst_o, NOP);
    chk("t4_pc",      d_pc_o, 32'h0);
    chk("t4_req",     {31'b0, bus.imem_req_o}, 32'd1);
    chk("t4_addr_tgt", bus.imem_addr_o, 32'h200);

    // grant withheld: request and address stay put
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_req_hold",  {31'b0, bus.imem_req_o}, 32'd1);
      chk("t5_addr_hold", bus.imem_addr_o, 32'h200);
    end
    rst_i = 1'b1; #1;
    chk("t5_rst_req",   {31'b0, bus.imem_req_o}, 32'd0);
    chk("t5_rst_addr",  bus.imem_addr_o, 32'h0);
    chk("t5_rst_valid", {31'b0, d_valid_o}, 32'd0);
    chk("t5_rst_inst",  d_inst_o, NOP);
    chk("t5_rst_pc",    d_pc_o, 32'h0);

    // PC wrap; a stray rvalid in S_IDLE is ignored
    rst_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h200);
    pc_load_i = 1'b1; pc_load_addr_i = 32'hFFFF_FFFF; #1;
    chk("t6_req_redir", {31'b0, bus.imem_req_o}, 32'd0);
    step();
    bus.imem_rvalid_i = 1'b0; pc_load_i = 1'b0; bus.imem_gnt_i = 1'b1; #1;
    chk("t6_stray_ignored", {31'b0, d_valid_o}, 32'd0);
    chk("t6_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
    chk("t6_req",      {31'b0, bus.imem_req_o}, 32'd1);
    chk("t6_nop",      d_inst_o, NOP);
    step();
    chk("t6_addr_wrap", bus.imem_addr_o, 32'h0);
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'hFFFF_FFFC); bus.imem_gnt_i = 1'b0; #1;
    step();
    bus.imem_rvalid_i = 1'b0; #1;
    chk("t6_pc_top",   d_pc_o, 32'hFFFF_FFFC);
    chk("t6_inst_top", d_inst_o, word(32'hFFFF_FFFC));
    chk("t6_addr_req", bus.imem_addr_o, 32'h0);
    incr_pc_i = 1'b1;
    step();
    chk("t6_popped",     {31'b0, d_valid_o}, 32'd0);
    chk("t6_nop_again",  d_inst_o, NOP);
    step();
    chk("t6_empty_pop",  {31'b0, d_valid_o}, 32'd0);
    chk("t6_empty_pc",   d_pc_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
